// File: rtl/clock_pkg.sv
// Shared constants, FSM state type and the packing helper for time_set_edit.
package clock_pkg;

  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;
  localparam int SEC_PER_DAY  = 86400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPLIT = 3'd1,
    ST_EDIT  = 3'd2,
    ST_PACK  = 3'd3,
    ST_LOAD  = 3'd4
  } state_t;

  // One-hot field select, used directly as the blink mask.
  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_HR   = 3'b100;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_SEC  = 3'b001;

  // h*3600 + m*60 + s with shifts and adds only:
  // 3600 = 2048+1024+512+16, 60 = 32+16+8+4.
  function automatic logic [16:0] hms_to_sec(input logic [4:0] h,
                                             input logic [5:0] m,
                                             input logic [5:0] s);
    logic [16:0] hh, mm, ss;
    hh = {12'd0, h};
    mm = {11'd0, m};
    ss = {11'd0, s};
    return (hh << 11) + (hh << 10) + (hh << 9) + (hh << 4)
         + (mm << 5)  + (mm << 4)  + (mm << 3) + (mm << 2) + ss;
  endfunction

  // Two-digit binary-to-BCD, tens in [7:4], units in [3:0].
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] t, u;
    t = v / 7'd10;
    u = v % 7'd10;
    return {t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// The arm flag masks the first cycle after reset so a button held
// through reset release does not look like a fresh press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic r_prev;
  logic r_arm;

  // Remember last level; arm one cycle after reset drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= btn;
      r_arm  <= 1'b1;
    end
  end

  assign evt = btn & ~r_prev & r_arm;

endmodule

// File: rtl/time_set_edit.sv
// Time-of-day editor: splits the running seconds count into h/m/s by
// repeated subtraction, lets the user edit each field, then packs the
// result back into seconds and strobes load.
// Optional: define TIME_SET_DEC_EN to enable the decrement button.
// HOUR_MAX must fit in the 5-bit hour register (<= 31).
module time_set_edit
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] cur_sec,
  output logic [16:0] set_sec,
  output logic        load,
  output logic        editing,
  output logic [3:0]  h1,
  output logic [3:0]  h2,
  output logic [3:0]  m1,
  output logic [3:0]  m2,
  output logic [3:0]  s1,
  output logic [3:0]  s2,
  output logic [2:0]  field
);

  localparam logic [4:0]  HR_MAX = 5'(HOUR_MAX);
  localparam logic [16:0] C_HOUR = 17'(SEC_PER_HOUR);
  localparam logic [16:0] C_MIN  = 17'(SEC_PER_MIN);

  // Button order in the edge array: [3]=mode [2]=sel [1]=inc [0]=dec.
  logic [3:0] w_btn;
  logic [3:0] w_ev;
  logic       w_mode_ev, w_sel_ev, w_inc_act, w_dec_act;

  state_t      r_state, w_next;
  logic [16:0] r_rem;
  logic [4:0]  r_hr;
  logic [5:0]  r_min, r_sec;
  logic [2:0]  r_field;
  logic [16:0] r_set;
  logic [7:0]  w_hbcd, w_mbcd, w_sbcd;

  assign w_btn = {btn_mode, btn_sel, btn_inc, btn_dec};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_edge
      btn_edge u_edge (
        .clk (clk),
        .rst (rst),
        .btn (w_btn[g]),
        .evt (w_ev[g])
      );
    end
  endgenerate

  assign w_mode_ev = w_ev[3];
  assign w_sel_ev  = w_ev[2];

`ifdef TIME_SET_DEC_EN
  // Coincident inc and dec cancel each other.
  assign w_inc_act = w_ev[1] & ~w_ev[0];
  assign w_dec_act = w_ev[0] & ~w_ev[1];
`else
  assign w_inc_act = w_ev[1];
  assign w_dec_act = w_ev[0] & 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next  = r_state;
    load    = 1'b0;
    editing = 1'b1;
    case (r_state)
      ST_IDLE: begin
        editing = 1'b0;
        if (w_mode_ev) w_next = ST_SPLIT;
      end
      ST_SPLIT: if (r_rem < C_MIN) w_next = ST_EDIT;
      ST_EDIT:  if (w_mode_ev) w_next = ST_PACK;
      ST_PACK:  w_next = ST_LOAD;
      ST_LOAD: begin
        load   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: split, field edits and packing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_hr    <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_field <= FLD_NONE;
      r_set   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_mode_ev) begin
          r_rem <= cur_sec;
          r_hr  <= '0;
          r_min <= '0;
          r_sec <= '0;
        end
        ST_SPLIT: begin
          if (r_rem >= C_HOUR) begin
            r_rem <= r_rem - C_HOUR;
            r_hr  <= r_hr + 5'd1;
          end else if (r_rem >= C_MIN) begin
            r_rem <= r_rem - C_MIN;
            r_min <= r_min + 6'd1;
          end else begin
            r_sec   <= r_rem[5:0];
            r_field <= FLD_HR;
          end
        end
        ST_EDIT: begin
          if (w_mode_ev) begin
            r_field <= FLD_NONE;
          end else begin
            // Inc/dec act on the field selected before any rotation.
            if (w_inc_act) begin
              case (r_field)
                FLD_HR:  r_hr  <= (r_hr >= HR_MAX) ? 5'd0 : r_hr + 5'd1;
                FLD_MIN: r_min <= (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
                FLD_SEC: r_sec <= (r_sec >= 6'd59) ? 6'd0 : r_sec + 6'd1;
                default: ;
              endcase
            end else if (w_dec_act) begin
              case (r_field)
                FLD_HR:  r_hr  <= (r_hr == 5'd0) ? HR_MAX : r_hr - 5'd1;
                FLD_MIN: r_min <= (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                FLD_SEC: r_sec <= (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
                default: ;
              endcase
            end
            if (w_sel_ev) r_field <= {r_field[0], r_field[2:1]};
          end
        end
        ST_PACK: r_set <= hms_to_sec(r_hr, r_min, r_sec);
        default: ;
      endcase
    end
  end

  assign w_hbcd = to_bcd({2'b00, r_hr});
  assign w_mbcd = to_bcd({1'b0, r_min});
  assign w_sbcd = to_bcd({1'b0, r_sec});

  assign {h1, h2} = w_hbcd;
  assign {m1, m2} = w_mbcd;
  assign {s1, s2} = w_sbcd;
  assign set_sec  = r_set;
  assign field    = r_field;

endmodule

// File: tb/tb_time_set_edit.sv
// Bench for time_set_edit: fixed vector tables, hand sequences for the
// multi-cycle corners, and random edit sessions against an h/m/s model.
module tb_time_set_edit;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_sel, btn_inc, btn_dec;
  logic [16:0] cur_sec, set_sec;
  logic        load, editing;
  logic [3:0]  h1, h2, m1, m2, s1, s2;
  logic [2:0]  field;

  time_set_edit #(.HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_sec(cur_sec), .set_sec(set_sec), .load(load), .editing(editing),
    .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2), .field(field)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m, s, i, d;
    int   eh, em, es, ef;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int mh, mm, ms, mf;   // model: hours, minutes, seconds, field index 0=hr 1=min 2=sec

`ifdef TIME_SET_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int oh(input int f);
    return (f == 0) ? 4 : (f == 1) ? 2 : 1;
  endfunction

  function automatic int bcd6(input int h, input int m, input int s);
    logic [23:0] d;
    d = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return int'(d);
  endfunction

  function automatic int dut_digits();
    return int'({h1, h2, m1, m2, s1, s2});
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, ".digits"}, dut_digits(), bcd6(mh, mm, ms));
    chk({nm, ".field"}, int'(field), oh(mf));
  endtask

  // Drive one button combination for a cycle, then release; returns on
  // the falling edge after the acting rising edge.
  task automatic step(input logic m, input logic s, input logic i, input logic d);
    @(negedge clk);
    btn_mode = m; btn_sel = s; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 0; btn_sel = 0; btn_inc = 0; btn_dec = 0;
  endtask

  // Model of one EDIT-state event combination (no mode).
  task automatic model_apply(input bit s, input bit i, input bit d);
    bit up, dn;
    up = DEC_EN ? (i && !d) : i;
    dn = DEC_EN ? (d && !i) : 1'b0;
    if (up) begin
      if (mf == 0) mh = (mh + 1) % 24;
      else if (mf == 1) mm = (mm + 1) % 60;
      else ms = (ms + 1) % 60;
    end else if (dn) begin
      if (mf == 0) mh = (mh + 23) % 24;
      else if (mf == 1) mm = (mm + 59) % 60;
      else ms = (ms + 59) % 60;
    end
    if (s) mf = (mf + 1) % 3;
  endtask

  task automatic enter_edit(input int cs, input string nm);
    int n;
    cur_sec = 17'(cs);
    mh = cs / 3600; mm = (cs % 3600) / 60; ms = cs % 60; mf = 0;
    step(1, 0, 0, 0);
    chk({nm, ".editing"}, int'(editing), 1);
    n = 0;
    while (field == 3'b000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".split_cycles"}, n, mh + mm + 1);
    chk_model(nm);
  endtask

  task automatic commit(input string nm);
    int exp;
    exp = mh * 3600 + mm * 60 + ms;
    @(negedge clk); btn_mode = 1;
    @(negedge clk); btn_mode = 0;
    chk({nm, ".pack_load"}, int'(load), 0);
    chk({nm, ".pack_field"}, int'(field), 0);
    @(negedge clk);
    chk({nm, ".load"}, int'(load), 1);
    chk({nm, ".set_sec"}, int'(set_sec), exp);
    @(negedge clk);
    chk({nm, ".load_end"}, int'(load), 0);
    chk({nm, ".idle"}, int'(editing), 0);
    chk({nm, ".set_hold"}, int'(set_sec), exp);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".editing"}, int'(editing), 0);
    chk({nm, ".load"}, int'(load), 0);
    chk({nm, ".field"}, int'(field), 0);
    chk({nm, ".set_sec"}, int'(set_sec), 0);
    chk({nm, ".digits"}, dut_digits(), 0);
  endtask

  vec_t ta[4];
  vec_t tb[6];

  initial begin
    // 23:59:59 start, hour selected.
    ta[0] = '{0, 0, 1, 0,  0, 59, 59, 4};
    ta[1] = '{0, 1, 0, 0,  0, 59, 59, 2};
    ta[2] = '{0, 1, 0, 0,  0, 59, 59, 1};
    ta[3] = '{0, 0, 1, 0,  0, 59,  0, 1};
    // 12:34:56 start, hour selected.
    tb[0] = '{0, 1, 1, 0, 13, 34, 56, 2};
    tb[1] = '{0, 0, 1, 0, 13, 35, 56, 2};
`ifdef TIME_SET_DEC_EN
    tb[2] = '{0, 0, 0, 1, 13, 34, 56, 2};
    tb[3] = '{0, 0, 1, 1, 13, 34, 56, 2};
    tb[4] = '{0, 1, 0, 0, 13, 34, 56, 1};
    tb[5] = '{0, 0, 0, 1, 13, 34, 55, 1};
`else
    tb[2] = '{0, 0, 0, 1, 13, 35, 56, 2};
    tb[3] = '{0, 0, 1, 1, 13, 36, 56, 2};
    tb[4] = '{0, 1, 0, 0, 13, 36, 56, 1};
    tb[5] = '{0, 0, 0, 1, 13, 36, 56, 1};
`endif

    rst = 1; btn_mode = 0; btn_sel = 0; btn_inc = 0; btn_dec = 0; cur_sec = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    // 12:34:56 split latency and digits.
    enter_edit(45296, "split45296");
    chk("split45296.hour_sel", int'(field), 4);
    commit("pack45296");

    // Table A: hour wrap, field rotation, seconds entry, pack 00:59:00.
    enter_edit(86399, "tA");
    foreach (ta[k]) begin
      step(ta[k].m, ta[k].s, ta[k].i, ta[k].d);
      chk($sformatf("tA%0d.digits", k), dut_digits(), bcd6(ta[k].eh, ta[k].em, ta[k].es));
      chk($sformatf("tA%0d.field", k), int'(field), ta[k].ef);
    end
    mh = 0; mm = 59; ms = 0;
    commit("tA_pack");
    chk("tA_pack.3540", int'(set_sec), 3540);

    // Table B: sel+inc ordering, dec and inc+dec handling.
    enter_edit(45296, "tB");
    foreach (tb[k]) begin
      step(tb[k].m, tb[k].s, tb[k].i, tb[k].d);
      chk($sformatf("tB%0d.digits", k), dut_digits(), bcd6(tb[k].eh, tb[k].em, tb[k].es));
      chk($sformatf("tB%0d.field", k), int'(field), tb[k].ef);
    end
    mh = tb[5].eh; mm = tb[5].em; ms = tb[5].es;
    // Mode together with inc: inc dropped, straight to PACK.
    @(negedge clk); btn_mode = 1; btn_inc = 1;
    @(negedge clk); btn_mode = 0; btn_inc = 0;
    chk("mode_inc.digits", dut_digits(), bcd6(mh, mm, ms));
    @(negedge clk);
    chk("mode_inc.load", int'(load), 1);
    chk("mode_inc.set_sec", int'(set_sec), mh * 3600 + mm * 60 + ms);
    @(negedge clk);

    // Zero time: one split cycle, pack gives 0.
    enter_edit(0, "zero");
    commit("zero_pack");

    // Downward wrap on min=0 and hr=0.
    enter_edit(0, "decwrap");
    step(0, 0, 0, 1); model_apply(0, 0, 1); chk_model("dec_hr0");
    step(0, 1, 0, 0); model_apply(1, 0, 0);
    step(0, 0, 0, 1); model_apply(0, 0, 1); chk_model("dec_min0");
    commit("decwrap_pack");

    // Held inc: one increment only.
    enter_edit(5 * 3600, "hold");
    @(negedge clk); btn_inc = 1;
    repeat (100) @(negedge clk);
    btn_inc = 0;
    @(negedge clk);
    mh = 6;
    chk_model("hold_inc");
    commit("hold_pack");

    // Presses during SPLIT are dropped.
    cur_sec = 17'd86399;
    step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 1, 1);
    begin
      int n = 0;
      while (field == 3'b000 && n < 200) begin @(negedge clk); n++; end
      chk("split_drop.timeout", int'(n < 200), 1);
    end
    mh = 23; mm = 59; ms = 59; mf = 0;
    chk_model("split_drop");
    commit("split_drop_pack");

    // Random edit sessions.
    for (int r = 0; r < 15; r++) begin
      enter_edit(int'($urandom_range(86399, 0)), $sformatf("rnd%0d", r));
      for (int k = 0; k < 8; k++) begin
        bit s, i, d;
        s = 1'($urandom); i = 1'($urandom); d = 1'($urandom);
        step(0, s, i, d);
        model_apply(s, i, d);
        chk_model($sformatf("rnd%0d_%0d", r, k));
      end
      commit($sformatf("rnd%0d_pack", r));
    end

    // Reset in the middle of a long split, mode held through release.
    cur_sec = 17'd86399;
    step(1, 0, 0, 0);
    repeat (39) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_zero("rst_mid_split");
    btn_mode = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("held_mode%0d.editing", k), int'(editing), 0);
      chk($sformatf("held_mode%0d.load", k), int'(load), 0);
    end
    btn_mode = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_edit.md
TIME_SET_EDIT -- requirements
Module: time_set_edit

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23: highest hour value; 0..HOUR_MAX, wraps to 0.
REQ-002 SHALL have port clk  in  1  system clock; single clock domain.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports btn_mode, btn_sel, btn_inc, btn_dec  in  1 each  raw levels, already debounced; acted on at rising edge only.
REQ-005 SHALL have port cur_sec  in  17  running seconds-of-day from the counter, 0..86399.
REQ-006 SHALL have port set_sec  out  17  edited seconds-of-day, meaning h*3600+m*60+s.
REQ-007 SHALL have port load  out  1  one-cycle strobe; the counter takes set_sec on it.
REQ-008 SHALL have port editing  out  1  high while in any non-IDLE state.
REQ-009 SHALL have ports h1,h2,m1,m2,s1,s2  out  4 each  BCD digits of edited time, tens then units.
REQ-010 SHALL have port field  out  3  one-hot selected field for display blink: [2]=hour, [1]=min, [0]=sec.

Function
REQ-011 SHALL detect input edges by registering each btn once; event = cur & ~prev.
REQ-012 SHALL implement FSM states IDLE, SPLIT, EDIT, PACK, LOAD.
REQ-013 IDLE: btn_mode event latches cur_sec into work register rem and goes to SPLIT with hr=min=sec=0.
REQ-014 SPLIT: per cycle, if rem>=3600 then rem-=3600, hr+=1; else if rem>=60 then rem-=60, min+=1; else sec=rem and go to EDIT.
REQ-015 SPLIT latency SHALL be hr+min+1 cycles: 83 maximum for 86399, 1 for 0.
REQ-016 EDIT: field resets to hour on entry; btn_sel event rotates field hour->min->sec->hour.
REQ-017 EDIT: btn_inc event increments the selected field and wraps: hr at HOUR_MAX->0, min/sec at 59->0; no carry into other fields.
REQ-018 EDIT: btn_mode event goes to PACK; inc, sel and dec in the same cycle as mode are ignored.
REQ-019 EDIT: simultaneous sel and inc events: inc applies to the old field, then field rotates.
REQ-020 PACK: set_sec <= hr*3600 + min*60 + sec computed in 17-bit arithmetic using shift-add; one cycle; next state LOAD.
REQ-021 LOAD: load=1 for exactly one cycle, then IDLE; set_sec holds until the next PACK.
REQ-022 Button events in SPLIT, PACK and LOAD SHALL be dropped, not queued.
REQ-023 Digit outputs SHALL be combinational binary-to-BCD of hr/min/sec, valid in all states.
REQ-024 field SHALL be 3'b000 outside EDIT.

Reset
REQ-025 rst SHALL force IDLE, hr=min=sec=0, rem=0, set_sec=0, load=0, field=0, edge registers=0, from any state including mid-SPLIT.
REQ-026 A button held high across reset release SHALL NOT produce an event.

Configuration
REQ-027 With TIME_SET_DEC_EN defined, a btn_dec event in EDIT SHALL decrement the selected field with wrap (hr 0->HOUR_MAX, min/sec 0->59); if inc and dec events coincide, neither applies.
REQ-028 Without TIME_SET_DEC_EN, btn_dec SHALL be ignored; the port stays present.

Structure
REQ-029 Package clock_pkg SHALL hold SEC_PER_HOUR=3600, SEC_PER_MIN=60, SEC_PER_DAY=86400, the FSM state enum and the field one-hot constants.
REQ-030 Sub-module btn_edge (one instance per button, rst-cleared) SHALL do edge detection; all else stays in time_set_edit.

Verification
REQ-031 cur_sec=45296, mode pulse -> SPLIT 12+34+1=47 cycles, digits 1,2,3,4,5,6, field=3'b100.
REQ-032 Edit 23:59:59, inc on hour -> 00:59:59; sel twice, inc -> 00:59:00; mode -> PACK, load high one cycle, set_sec=3540.
REQ-033 cur_sec=0, mode -> EDIT after 1 cycle; mode again -> set_sec=0, load pulse, editing low after LOAD.
REQ-034 rst asserted mid-SPLIT (cur_sec=86399, cycle 40) -> next cycle IDLE, all outputs 0, no load.
REQ-035 With TIME_SET_DEC_EN: min=0, dec -> 59; inc+dec same cycle -> unchanged; without macro, dec -> unchanged.
REQ-036 btn_inc held high 100 cycles -> exactly one increment; inc events during SPLIT -> no change.
